// File: rtl/shift_rows_stage.sv
// Registered Rijndael ShiftRows / InvShiftRows stage for 4, 6 or 8 column states.
// A two-entry output FIFO holds final shifted results together with the direction bit and the user tag.
module shift_rows_stage #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic                out_inv,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W      = 32 * NB;
  localparam int NBYTES = 4 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_stage: NB must be 4, 6 or 8");
    end
  endgenerate

  // Rows 2 and 3 shift one further for the 256-bit block.
  function automatic int row_offset(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted;

  always_comb begin
    fwd_data = '0;
    inv_data = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        fwd_data[8*(NBYTES-1-(4*c+r)) +: 8] =
          in_data[8*(NBYTES-1-(4*((c+row_offset(r)) % NB)+r)) +: 8];
        inv_data[8*(NBYTES-1-(4*c+r)) +: 8] =
          in_data[8*(NBYTES-1-(4*((c+NB-row_offset(r)) % NB)+r)) +: 8];
      end
    end
    shifted = in_inv ? inv_data : fwd_data;
  end

  logic [W-1:0]     mem_data [2];
  logic             mem_inv  [2];
  logic [TAG_W-1:0] mem_tag  [2];
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             wptr;
  logic             rptr;
  logic             ready_q;
  logic             push;
  logic             pop;

  // Reset masks the handshakes directly so nothing is offered or taken while rst is high.
  assign in_ready  = ready_q & ~rst;
  assign out_valid = (count != 2'd0) & ~rst;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = mem_data[rptr];
  assign out_inv  = mem_inv[rptr];
  assign out_tag  = mem_tag[rptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_inv[i]  <= 1'b0;
        mem_tag[i]  <= '0;
      end
    end else begin
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
      if (push) begin
        mem_data[wptr] <= shifted;
        mem_inv[wptr]  <= in_inv;
        mem_tag[wptr]  <= in_tag;
        wptr           <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_stage.sv
// Bench for shift_rows_stage: three instances (NB=4,6,8) driven by directed steps,
// results checked against a queued reference model as they leave each stage.
module tb_shift_rows_stage;

  typedef struct {
    logic [255:0] data;
    logic         inv;
    logic [3:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]      in_valid, in_inv, out_ready;
  logic [2:0]      in_ready, out_valid, out_inv;
  logic [2:0][3:0] in_tag, out_tag;
  logic [127:0]    din4, dout4;
  logic [191:0]    din6, dout6;
  logic [255:0]    din8, dout8;

  exp_t sbq [3][$];
  int   pops [3];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_rows_stage #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(din4),
    .in_inv(in_inv[0]), .in_tag(in_tag[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(dout4), .out_inv(out_inv[0]), .out_tag(out_tag[0]));

  shift_rows_stage #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(din6),
    .in_inv(in_inv[1]), .in_tag(in_tag[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(dout6), .out_inv(out_inv[1]), .out_tag(out_tag[1]));

  shift_rows_stage #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(din8),
    .in_inv(in_inv[2]), .in_tag(in_tag[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(dout8), .out_inv(out_inv[2]), .out_tag(out_tag[2]));

  function automatic int nb_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 6 : 8;
  endfunction

  function automatic logic [255:0] get_dout(input int i);
    case (i)
      0:       return {128'b0, dout4};
      1:       return {64'b0, dout6};
      default: return dout8;
    endcase
  endfunction

  function automatic logic [255:0] get_din(input int i);
    case (i)
      0:       return {128'b0, din4};
      1:       return {64'b0, din6};
      default: return din8;
    endcase
  endfunction

  task automatic set_din(input int i, input logic [255:0] d);
    case (i)
      0:       din4 = d[127:0];
      1:       din6 = d[191:0];
      default: din8 = d;
    endcase
  endtask

  // Reference row shift, result right-aligned in 256 bits.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input logic inv);
    logic [255:0] r;
    int nbytes, off, src;
    r = '0;
    nbytes = 4 * nb;
    for (int row = 0; row < 4; row++) begin
      off = (nb == 8 && row >= 2) ? row + 1 : row;
      for (int col = 0; col < nb; col++) begin
        src = inv ? (col + nb - off) % nb : (col + off) % nb;
        r[8*(nbytes-1-(4*col+row)) +: 8] = d[8*(nbytes-1-(4*src+row)) +: 8];
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops compared first, then the accepted input is queued.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          pops[i]++;
          if (sbq[i].size() == 0) begin
            check($sformatf("spurious_out%0d", i), 256'(out_valid[i]), 256'(0));
          end else begin
            exp_t e;
            e = sbq[i].pop_front();
            check($sformatf("sb_data%0d", i), get_dout(i), e.data);
            check($sformatf("sb_inv%0d", i), 256'(out_inv[i]), 256'(e.inv));
            check($sformatf("sb_tag%0d", i), 256'(out_tag[i]), 256'(e.tag));
          end
        end
        if (in_valid[i] && in_ready[i]) begin
          exp_t e;
          e.data = ref_shift(get_din(i), nb_of(i), in_inv[i]);
          e.inv  = in_inv[i];
          e.tag  = in_tag[i];
          sbq[i].push_back(e);
        end
      end
    end
  end

  // Offer one state and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input int i, input logic [255:0] d, input logic inv, input logic [3:0] tag);
    bit done;
    bit was_ready;
    done = 0;
    set_din(i, d);
    in_inv[i]   = inv;
    in_tag[i]   = tag;
    in_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      was_ready = in_ready[i];
      @(posedge clk);
      #1;
      if (was_ready) done = 1;
    end
    in_valid[i] = 1'b0;
    if (!done) check("send_timeout", 256'(in_ready[i]), 256'(1));
  endtask

  initial begin
    logic [255:0] asc, fwd8, a6, b6, c6, d;
    int p0;

    rst = 1'b1;
    in_valid = '0; in_inv = '0; out_ready = '1; in_tag = '0;
    din4 = '0; din6 = '0; din8 = '0;
    for (int i = 0; i < 3; i++) pops[i] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(3'b111));
    check("post_rst_out_valid", 256'(out_valid), 256'(0));
    check("post_rst_dout4", get_dout(0), '0);
    check("post_rst_dout8", get_dout(2), '0);
    check("post_rst_inv_tag", 256'({out_inv, out_tag}), 256'(0));

    // NB=4 forward and inverse known vectors
    send(0, 256'h0d42711aee0bf98f1b8b45de51e415230 & {128'b0, {128{1'b1}}}, 1'b0, 4'd3);
    check("nb4_fwd_valid", 256'(out_valid[0]), 256'(1));
    check("nb4_fwd_data", get_dout(0), 256'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("nb4_fwd_tag", 256'(out_tag[0]), 256'(3));
    check("nb4_fwd_inv", 256'(out_inv[0]), 256'(0));
    send(0, 256'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'd5);
    check("nb4_inv_data", get_dout(0), 256'hd42711aee0bf98f1b8b45de51e415230);
    check("nb4_inv_inv", 256'(out_inv[0]), 256'(1));

    // NB=8 forward on ascending bytes, then invert back
    for (int k = 0; k < 32; k++) asc[8*(31-k) +: 8] = 8'(k);
    send(2, asc, 1'b0, 4'd1);
    check("nb8_r2c0", 256'(dout8[239:232]), 256'h0e);
    check("nb8_r3c0", 256'(dout8[231:224]), 256'h13);
    fwd8 = ref_shift(asc, 8, 1'b0);
    send(2, fwd8, 1'b1, 4'd2);
    check("nb8_roundtrip", get_dout(2), asc);

    // NB=6 backpressure: A, B accepted, C held
    a6 = {64'b0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b6 = {64'b0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    c6 = {64'b0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    out_ready[1] = 1'b0;
    @(posedge clk); #1;
    set_din(1, a6); in_inv[1] = 1'b0; in_tag[1] = 4'd10; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    set_din(1, b6); in_inv[1] = 1'b1; in_tag[1] = 4'd11;
    @(posedge clk); #1;
    check("bp_full_ready", 256'(in_ready[1]), 256'(0));
    set_din(1, c6); in_inv[1] = 1'b0; in_tag[1] = 4'd12;
    @(posedge clk); #1;
    check("bp_hold_ready", 256'(in_ready[1]), 256'(0));
    check("bp_hold_valid", 256'(out_valid[1]), 256'(1));
    check("bp_stable_a", get_dout(1), ref_shift(a6, 6, 1'b0));
    @(posedge clk); #1;
    check("bp_stable_a2", get_dout(1), ref_shift(a6, 6, 1'b0));
    check("bp_stable_tag", 256'(out_tag[1]), 256'(10));
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("bp_reraise_ready", 256'(in_ready[1]), 256'(1));
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_pops", 256'(pops[1]), 256'(3));

    // NB=4 streaming, alternating direction, one per cycle
    p0 = pops[0];
    for (int n = 0; n < 100; n++) begin
      d = {128'b0, $urandom, $urandom, $urandom, $urandom};
      set_din(0, d); in_inv[0] = n[0]; in_tag[0] = 4'(n); in_valid[0] = 1'b1;
      @(posedge clk); #1;
      check("stream_ready", 256'(in_ready[0]), 256'(1));
      check("stream_valid", 256'(out_valid[0]), 256'(1));
    end
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_pops", 256'(pops[0] - p0), 256'(100));

    // Reset with NB=6 buffer full: held entries must vanish
    out_ready[1] = 1'b0;
    send(1, a6, 1'b0, 4'd7);
    send(1, b6, 1'b1, 4'd8);
    check("full_before_rst", 256'(in_ready[1]), 256'(0));
    p0 = pops[1];
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 256'(in_ready[1]), 256'(0));
    check("rst_mid_out_valid", 256'(out_valid[1]), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("after_rst_valid", 256'(out_valid[1]), 256'(0));
    check("after_rst_ready", 256'(in_ready[1]), 256'(1));
    check("after_rst_data", get_dout(1), '0);
    out_ready[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("after_rst_no_out", 256'(pops[1] - p0), 256'(0));

    for (int n = 0; n < 50; n++) begin
      if (sbq[0].size() + sbq[1].size() + sbq[2].size() == 0) break;
      @(negedge clk);
    end
    check("sb_drained", 256'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_rows_stage.md
# shift_rows_stage

Parametrised, registered Rijndael row-shift stage covering forward ShiftRows and InvShiftRows for block widths of 4, 6 or 8 columns, with the direction selected per transaction. It sits in the round datapath between SubBytes/InvSubBytes and MixColumns/InvMixColumns. It replaces the fixed 128-bit combinational inverse shifter with a valid/ready pipeline stage. A two-entry output buffer gives full throughput under backpressure and carries a user tag alongside the data.

## Interface
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error
- TAG_W, 4, width of sideband tag carried with each transaction (≥1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream offers a state
- in_ready  output  1  stage can accept; registered, independent of in_valid
- in_data  input  32*NB  state; byte k (bits [8*(4*NB-1-k)+7 : 8*(4*NB-1-k)]) is row k%4, column k/4
- in_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows
- in_tag  input  TAG_W  sideband, passed unchanged
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out_data  output  32*NB  shifted state, same byte layout
- out_inv  output  1  copy of in_inv for this result
- out_tag  output  TAG_W  copy of in_tag for this result

## Operation
- Row offsets C(r): NB=4 or 6 → 0,1,2,3; NB=8 → 0,1,3,4.
- Forward: out(r,c) = in(r,(c+C(r)) mod NB). Inverse: out(r,(c+C(r)) mod NB) = in(r,c).
- The shift is computed combinationally on in_data and written into the buffer on acceptance, so stored entries hold final results.
- Buffer: 2-entry FIFO with a 2-bit count (0..2), write pointer and read pointer (1 bit each, wrap 1→0). Each entry holds {data, inv, tag}.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != 2), registered: derived from the next count value.
- out_valid = (count != 0); out_data/out_inv/out_tag driven from the head entry.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- Full (count=2): in_ready=0, in_data ignored, no overwrite. Empty: out_valid=0, out_ready ignored.
- in_inv is sampled per transaction. Mixed forward/inverse traffic back-to-back is legal and needs no bubble.
- Reset (rst=1 at a rising edge): count, both pointers and all entry contents go to 0. Any held entries are discarded.
- While rst is high, in_ready=0 and out_valid=0, regardless of inputs.
- Reset mid-transfer drops the in-flight data; no partial output appears after reset.
- Reset values: in_ready=1 on the first cycle after rst deasserts. out_valid=0. out_data=0, out_inv=0, out_tag=0.

## Timing
- Latency: a state accepted at edge t is on out_data with out_valid=1 from edge t to t+1 (one cycle).
- Throughput: one transaction per cycle when out_ready is held high (count oscillates 0↔1 or stays 1).
- Backpressure: with out_ready=0, two pushes fill the buffer and in_ready drops after the second accepting edge. The first pop re-raises in_ready on the following cycle.
- out_data/out_inv/out_tag remain stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Test plan
- NB=4 forward: in_data=d42711aee0bf98f1b8b45de51e415230, in_inv=0, tag=3 → one cycle later out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=3, out_inv=0.
- NB=4 inverse: in_data=d4bf5d30e0b452aeb84111f11e2798e5, in_inv=1 → out_data=d42711aee0bf98f1b8b45de51e415230.
- NB=8 forward, bytes 00..1f ascending, in_inv=0:
  - row 2 of output column 0 = 0e (offset 3)
  - row 3 of output column 0 = 13 (offset 4)
  - inverse of that result restores 00..1f
- Backpressure, NB=6:
  - push A, B, C on consecutive cycles with out_ready=0 → A and B accepted, in_ready=0 while C is held.
  - release out_ready → outputs A, B, C in order with matching tags; no loss or duplication.
- Streaming with alternating in_inv=0/1 for 100 random states, out_ready held 1 → one result per cycle, each matching the reference model for its mode.
- Assert rst for one cycle with count=2 → next cycle out_valid=0, in_ready=1, out_data=0. Neither held entry ever appears.
